// File: rtl/scaler_pkg.sv
// Shared constants and state encoding for the horizontal 2:1 down-scaler.
package scaler_pkg;

    localparam int DEF_WIDTH  = 10;
    localparam int LINE_CNT_W = 16;
    localparam logic [LINE_CNT_W-1:0] LINE_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_PAIR = 2'd2
    } scaler_state_t;

endpackage

// File: rtl/pixel_avg2.sv
// Rounded average of two pixels of one colour channel: (a+b+1)>>1.
// Latency: combinational.
// Backpressure: none.
module pixel_avg2
    import scaler_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] avg
);

    // One extra bit of headroom: the all-ones pair still fits before the shift.
    logic [WIDTH:0] sum;

    assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, 1'b1};
    assign avg = WIDTH'(sum >> 1);

endmodule

// File: rtl/h_down_scaler.sv
// Horizontal 2:1 down-scaler: averages adjacent active pixel pairs, optional 2:1 line drop.
// Latency: one cycle for syncs and for each emitted pixel (pair or odd trailing pixel).
// Backpressure: none; free-running pixel stream, one output pulse per pair.
module h_down_scaler
    import scaler_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit VSYNC_POL = 1'b0,
    parameter bit HSYNC_POL = 1'b0,
    parameter int V_DECIM   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vsync,
    input  logic             i_hsync,
    input  logic             i_de,
    input  logic [WIDTH-1:0] i_r_data,
    input  logic [WIDTH-1:0] i_g_data,
    input  logic [WIDTH-1:0] i_b_data,
    output logic             o_vsync,
    output logic             o_hsync,
    output logic             o_de,
    output logic [WIDTH-1:0] o_r_data,
    output logic [WIDTH-1:0] o_g_data,
    output logic [WIDTH-1:0] o_b_data
);

    scaler_state_t         state;
    logic [WIDTH-1:0]      hold_r, hold_g, hold_b;
    logic [WIDTH-1:0]      avg_r, avg_g, avg_b;
    logic [LINE_CNT_W-1:0] line_cnt;
    logic                  de_d;
    logic                  vs_act_d;
    logic                  vs_act;
    logic                  vs_edge;
    logic                  de_fall;
    logic                  drop_line;

    assign vs_act    = i_vsync ^ VSYNC_POL;
    assign vs_edge   = vs_act & ~vs_act_d;
    assign de_fall   = de_d & ~i_de;
    // The trailing odd pixel is flushed on the de falling edge, before the count moves on.
    assign drop_line = (V_DECIM != 0) && line_cnt[0];

    pixel_avg2 #(.WIDTH(WIDTH)) u_avg_r (.a(hold_r), .b(i_r_data), .avg(avg_r));
    pixel_avg2 #(.WIDTH(WIDTH)) u_avg_g (.a(hold_g), .b(i_g_data), .avg(avg_g));
    pixel_avg2 #(.WIDTH(WIDTH)) u_avg_b (.a(hold_b), .b(i_b_data), .avg(avg_b));

    always_ff @(posedge clk) begin
        if (rst) begin
            line_cnt <= '0;
        end else if (vs_edge) begin
            line_cnt <= '0;
        end else if (de_fall && (line_cnt != LINE_CNT_MAX)) begin
            line_cnt <= line_cnt + LINE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            hold_r   <= '0;
            hold_g   <= '0;
            hold_b   <= '0;
            de_d     <= 1'b0;
            vs_act_d <= 1'b0;
            o_vsync  <= VSYNC_POL;
            o_hsync  <= HSYNC_POL;
            o_de     <= 1'b0;
            o_r_data <= '0;
            o_g_data <= '0;
            o_b_data <= '0;
        end else begin
            de_d     <= i_de;
            vs_act_d <= vs_act;
            o_vsync  <= i_vsync;
            o_hsync  <= i_hsync;
            o_de     <= 1'b0;
            o_r_data <= '0;
            o_g_data <= '0;
            o_b_data <= '0;

            // Frame start wins over everything: a half-built pair never leaks into the new frame.
            if (vs_edge) begin
                state  <= S_IDLE;
                hold_r <= '0;
                hold_g <= '0;
                hold_b <= '0;
            end else begin
                case (state)
                    S_HOLD: begin
                        if (i_de) begin
                            state <= S_PAIR;
                            if (!drop_line) begin
                                o_de     <= 1'b1;
                                o_r_data <= avg_r;
                                o_g_data <= avg_g;
                                o_b_data <= avg_b;
                            end
                        end else begin
                            state <= S_IDLE;
                            if (!drop_line) begin
                                o_de     <= 1'b1;
                                o_r_data <= hold_r;
                                o_g_data <= hold_g;
                                o_b_data <= hold_b;
                            end
                        end
                    end
                    default: begin
                        if (i_de) begin
                            state  <= S_HOLD;
                            hold_r <= i_r_data;
                            hold_g <= i_g_data;
                            hold_b <= i_b_data;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_h_down_scaler.sv
// Directed bench: three scaler instances (default, line-drop, inverted sync polarity) on one stream.
module tb_h_down_scaler;

    typedef struct {
        int cyc;
        int r;
        int g;
        int b;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vs = 1'b0, hs = 1'b0, de = 1'b0;
    logic [9:0] r_in = '0;
    logic [9:0] g_in, b_in;

    logic       rst_s = 1'b1, vs_s = 1'b0, hs_s = 1'b0;

    logic       o0_vs, o0_hs, o0_de;
    logic [9:0] o0_r, o0_g, o0_b;
    logic       ov_vs, ov_hs, ov_de;
    logic [9:0] ov_r, ov_g, ov_b;
    logic       op_vs, op_hs, op_de;
    logic [9:0] op_r, op_g, op_b;

    int  cyc = 0;
    int  n_vec = 0;
    int  n_err = 0;
    logic smp_vld = 1'b0;
    logic rst_q = 1'b1, vs_q = 1'b0, hs_q = 1'b0;

    ev_t ev0[$];
    ev_t evv[$];
    ev_t evp[$];
    ev_t exp_q[$];
    int  px[$];
    int  px_cyc[$];

    assign g_in = r_in ^ 10'h2AA;
    assign b_in = ~r_in;

    always #5 clk = ~clk;

    h_down_scaler #(.WIDTH(10)) dut0 (
        .clk(clk), .rst(rst), .i_vsync(vs), .i_hsync(hs), .i_de(de),
        .i_r_data(r_in), .i_g_data(g_in), .i_b_data(b_in),
        .o_vsync(o0_vs), .o_hsync(o0_hs), .o_de(o0_de),
        .o_r_data(o0_r), .o_g_data(o0_g), .o_b_data(o0_b)
    );

    h_down_scaler #(.WIDTH(10), .V_DECIM(1)) dut_v (
        .clk(clk), .rst(rst), .i_vsync(vs), .i_hsync(hs), .i_de(de),
        .i_r_data(r_in), .i_g_data(g_in), .i_b_data(b_in),
        .o_vsync(ov_vs), .o_hsync(ov_hs), .o_de(ov_de),
        .o_r_data(ov_r), .o_g_data(ov_g), .o_b_data(ov_b)
    );

    h_down_scaler #(.WIDTH(10), .VSYNC_POL(1'b1), .HSYNC_POL(1'b1)) dut_p (
        .clk(clk), .rst(rst), .i_vsync(~vs), .i_hsync(~hs), .i_de(de),
        .i_r_data(r_in), .i_g_data(g_in), .i_b_data(b_in),
        .o_vsync(op_vs), .o_hsync(op_hs), .o_de(op_de),
        .o_r_data(op_r), .o_g_data(op_g), .o_b_data(op_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int avg2(input int a, input int b);
        return (a + b + 1) >> 1;
    endfunction

    // r is a hand value; g/b follow from the g=r^0x2AA and b=~r input mapping.
    task automatic push_exp(input int r, input int a, input int b, input int c);
        ev_t e;
        e.cyc = c;
        e.r   = r;
        e.g   = avg2(a ^ 682, b ^ 682);
        e.b   = avg2(1023 - a, 1023 - b);
        exp_q.push_back(e);
    endtask

    task automatic check_q(input string tag, input int which);
        ev_t got[$];
        if (which == 0) got = ev0;
        else if (which == 1) got = evv;
        else got = evp;
        chk({tag, ".count"}, got.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            chk($sformatf("%s.r%0d", tag, k),   got[k].r,   exp_q[k].r);
            chk($sformatf("%s.g%0d", tag, k),   got[k].g,   exp_q[k].g);
            chk($sformatf("%s.b%0d", tag, k),   got[k].b,   exp_q[k].b);
            chk($sformatf("%s.cyc%0d", tag, k), got[k].cyc, exp_q[k].cyc);
        end
    endtask

    task automatic tick(input logic d, input int r);
        @(posedge clk);
        #1;
        rst  = rst_s;
        vs   = vs_s;
        hs   = hs_s;
        de   = d;
        r_in = 10'(r);
    endtask

    task automatic drive_line();
        px_cyc.delete();
        hs_s = 1'b1;
        tick(1'b0, 0);
        tick(1'b0, 0);
        hs_s = 1'b0;
        tick(1'b0, 0);
        foreach (px[k]) begin
            tick(1'b1, px[k]);
            px_cyc.push_back(cyc);
        end
        tick(1'b0, 0);
        tick(1'b0, 0);
        tick(1'b0, 0);
    endtask

    task automatic clear_all();
        ev0.delete();
        evv.delete();
        evp.delete();
        exp_q.delete();
    endtask

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        smp_vld <= 1'b1;
        rst_q   <= rst;
        vs_q    <= vs;
        hs_q    <= hs;
    end

    // Syncs are the input one cycle late (inactive level across reset); idle data must be zero.
    always @(negedge clk) begin
        if (smp_vld) begin
            chk("vsync0", o0_vs, rst_q ? 1'b0 : vs_q);
            chk("hsync0", o0_hs, rst_q ? 1'b0 : hs_q);
            chk("vsyncv", ov_vs, rst_q ? 1'b0 : vs_q);
            chk("hsyncv", ov_hs, rst_q ? 1'b0 : hs_q);
            chk("vsyncp", op_vs, rst_q ? 1'b1 : !vs_q);
            chk("hsyncp", op_hs, rst_q ? 1'b1 : !hs_q);
            if (!o0_de) chk("zero0", {o0_r, o0_g, o0_b}, 0);
            if (!ov_de) chk("zerov", {ov_r, ov_g, ov_b}, 0);
        end
        if (o0_de) ev0.push_back('{cyc, int'(o0_r), int'(o0_g), int'(o0_b)});
        if (ov_de) evv.push_back('{cyc, int'(ov_r), int'(ov_g), int'(ov_b)});
        if (op_de) evp.push_back('{cyc, int'(op_r), int'(op_g), int'(op_b)});
    end

    initial begin
        int t1_exp[5] = '{1, 5, 9, 13, 17};
        int c[10];

        // Reset state
        rst_s = 1'b1;
        tick(1'b0, 0);
        tick(1'b0, 0);
        @(negedge clk);
        chk("rst.de0",   o0_de, 0);
        chk("rst.data0", {o0_r, o0_g, o0_b}, 0);
        chk("rst.vsp",   op_vs, 1);
        chk("rst.hsp",   op_hs, 1);
        rst_s = 1'b0;
        tick(1'b0, 0);
        tick(1'b0, 0);

        // Even-length line, pixels 0,2,..,18
        clear_all();
        px = '{0, 2, 4, 6, 8, 10, 12, 14, 16, 18};
        drive_line();
        for (int j = 0; j < 5; j++) push_exp(t1_exp[j], 4 * j, 4 * j + 2, px_cyc[2 * j + 1] + 1);
        check_q("hact10", 0);
        check_q("hact10p", 2);

        // Odd-length line, trailing pixel 100 flushed unaveraged
        clear_all();
        px = '{10, 20, 30, 40, 50, 60, 70, 80, 100};
        drive_line();
        push_exp(15, 10, 20, px_cyc[1] + 1);
        push_exp(35, 30, 40, px_cyc[3] + 1);
        push_exp(55, 50, 60, px_cyc[5] + 1);
        push_exp(75, 70, 80, px_cyc[7] + 1);
        push_exp(100, 100, 100, px_cyc[8] + 2);
        check_q("hact9", 0);

        // Full-scale rounding without overflow
        clear_all();
        px = '{1023, 1023, 1022, 1023};
        drive_line();
        push_exp(1023, 1023, 1023, px_cyc[1] + 1);
        push_exp(1023, 1022, 1023, px_cyc[3] + 1);
        check_q("fullscale", 0);

        // Vertical decimation over a 4-line frame
        vs_s = 1'b1;
        tick(1'b0, 0);
        tick(1'b0, 0);
        vs_s = 1'b0;
        tick(1'b0, 0);
        for (int l = 0; l < 4; l++) begin
            clear_all();
            px = '{100 * l, 100 * l + 2, 100 * l + 4, 100 * l + 6};
            drive_line();
            push_exp(100 * l + 1, 100 * l,     100 * l + 2, px_cyc[1] + 1);
            push_exp(100 * l + 5, 100 * l + 4, 100 * l + 6, px_cyc[3] + 1);
            check_q($sformatf("vdec.all%0d", l), 0);
            if (l % 2 == 0) check_q($sformatf("vdec.keep%0d", l), 1);
            else chk($sformatf("vdec.drop%0d", l), evv.size(), 0);
        end

        // Reset for one cycle after pixel 4: held pixel is lost, pairing restarts at pixel 5
        clear_all();
        hs_s = 1'b1;
        tick(1'b0, 0);
        hs_s = 1'b0;
        tick(1'b0, 0);
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 40 + 2 * k);
            c[k] = cyc;
        end
        rst_s = 1'b1;
        hs_s  = 1'b1;
        tick(1'b0, 0);
        rst_s = 1'b0;
        hs_s  = 1'b0;
        for (int k = 5; k < 10; k++) begin
            tick(1'b1, 40 + 2 * k);
            c[k] = cyc;
        end
        tick(1'b0, 0);
        tick(1'b0, 0);
        tick(1'b0, 0);
        push_exp(41, 40, 42, c[1] + 1);
        push_exp(45, 44, 46, c[3] + 1);
        push_exp(51, 50, 52, c[6] + 1);
        push_exp(55, 54, 56, c[8] + 1);
        push_exp(58, 58, 58, c[9] + 2);
        check_q("midrst", 0);

        // Vsync edge during active de drops the held pixel and the coincident one
        clear_all();
        hs_s = 1'b1;
        tick(1'b0, 0);
        hs_s = 1'b0;
        tick(1'b0, 0);
        tick(1'b1, 10);
        tick(1'b1, 20);
        c[1] = cyc;
        tick(1'b1, 30);
        vs_s = 1'b1;
        tick(1'b1, 40);
        vs_s = 1'b0;
        tick(1'b1, 50);
        tick(1'b1, 60);
        c[5] = cyc;
        tick(1'b0, 0);
        tick(1'b0, 0);
        tick(1'b0, 0);
        push_exp(15, 10, 20, c[1] + 1);
        push_exp(55, 50, 60, c[5] + 1);
        check_q("vsmid", 0);

        // Five 3-line frames of 5 pixels: counter must restart every frame
        clear_all();
        px = '{8, 16, 24, 32, 40};
        for (int f = 0; f < 5; f++) begin
            vs_s = 1'b1;
            tick(1'b0, 0);
            tick(1'b0, 0);
            vs_s = 1'b0;
            tick(1'b0, 0);
            for (int l = 0; l < 3; l++) drive_line();
            chk($sformatf("frm%0d.vdec", f), evv.size(), 6 * (f + 1));
        end
        chk("frames.pol", evp.size(), 45);
        chk("frames.all", ev0.size(), 45);

        tick(1'b0, 0);
        tick(1'b0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
